program_store: RTL and testbench

Parametrised, loadable instruction store for the 8-bit processor. It replaces the fixed, initialised instruction ROM. A byte-serial loader fills the store at run time. The fetch side returns a registered instruction one cycle after the request, plus a valid flag and an out-of-range error. The block sits between the external program loader and the core's fetch stage.

---
 rtl/program_store_if.sv | 35 +++
 rtl/program_store.sv | 152 +++++++++++++++
 tb/tb_program_store.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_store_if.sv
`default_nettype none
// ============================================================================
// Module   : program_store_if
// Purpose  : Loader and fetch signal bundle for the loadable program store.
// Revision : 1.0 - initial release
// ============================================================================
interface program_store_if #(
    parameter int INSTR_W = 20,
    parameter int ADDR_W  = 4
);
    logic               load_start;
    logic               load_end;
    logic               load_valid;
    logic [7:0]         load_data;
    logic               load_ready;
    logic               load_done;
    logic [ADDR_W:0]    word_count;
    logic               busy;
    logic               fetch_en;
    logic [ADDR_W-1:0]  fetch_addr;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               fetch_err;

    modport master (
        output load_start, load_end, load_valid, load_data, fetch_en, fetch_addr,
        input  load_ready, load_done, word_count, busy, instr, instr_valid, fetch_err
    );

    modport slave (
        input  load_start, load_end, load_valid, load_data, fetch_en, fetch_addr,
        output load_ready, load_done, word_count, busy, instr, instr_valid, fetch_err
    );
endinterface
`default_nettype wire

// File: rtl/program_store.sv
`default_nettype none
// ============================================================================
// Module   : program_store
// Purpose  : Byte-serial loadable instruction store with registered fetch port.
// Revision : 1.0 - initial release
// ============================================================================
module program_store #(
    parameter int INSTR_W = 20,
    parameter int ADDR_W  = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    program_store_if.slave   bus
);
    localparam int c_depth = 2 ** ADDR_W;
    localparam int c_bytes = (INSTR_W + 7) / 8;
    localparam int c_cnt_w = (c_bytes > 1) ? $clog2(c_bytes) : 1;
    localparam int c_sh_w  = (c_bytes > 1) ? (c_bytes - 1) * 8 : 8;
    localparam logic [c_cnt_w-1:0] c_last_byte = c_cnt_w'(c_bytes - 1);
    localparam logic [ADDR_W:0]    c_last_word = (ADDR_W + 1)'(c_depth - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_LOAD = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [ADDR_W:0]      r_wr_ptr;
    logic [ADDR_W:0]      r_word_count;
    logic [c_cnt_w-1:0]   r_byte_cnt;
    logic                 r_load_done;
    logic [INSTR_W-1:0]   r_instr;
    logic                 r_instr_valid;
    logic                 r_fetch_err;
    logic [INSTR_W-1:0]   r_mem [c_depth];

    logic                 w_accept;
    logic                 w_wr_en;
    logic                 w_clear;
    logic                 w_done;
    logic [INSTR_W-1:0]   w_word;

    always_comb begin
        w_next_state = r_state;
        w_clear      = 1'b0;
        w_done       = 1'b0;
        w_accept     = (r_state == S_LOAD) && bus.load_valid;
        w_wr_en      = w_accept && (r_byte_cnt == c_last_byte) && !bus.load_start;
        case (r_state)
            S_IDLE: begin
                if (bus.load_start) begin
                    w_next_state = S_LOAD;
                    w_clear      = 1'b1;
                end
            end
            S_LOAD: begin
                // A restart outranks both termination causes and suppresses load_done.
                if (bus.load_start) begin
                    w_clear = 1'b1;
                end else if ((w_wr_en && (r_wr_ptr == c_last_word)) || bus.load_end) begin
                    w_next_state = S_IDLE;
                    w_done       = 1'b1;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_load_done <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_load_done <= w_done;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_word_count <= '0;
            r_byte_cnt   <= '0;
        end else if (w_clear) begin
            r_wr_ptr     <= '0;
            r_word_count <= '0;
            r_byte_cnt   <= '0;
        end else if (w_accept) begin
            if (r_byte_cnt == c_last_byte) begin
                r_wr_ptr     <= r_wr_ptr + (ADDR_W + 1)'(1);
                r_word_count <= r_word_count + (ADDR_W + 1)'(1);
                r_byte_cnt   <= '0;
            end else begin
                r_byte_cnt   <= r_byte_cnt + c_cnt_w'(1);
            end
        end
    end

    // The word is assembled from the bytes already shifted in plus the byte
    // arriving now; truncation drops the unused high bits of the first byte.
    generate
        if (c_bytes == 1) begin : g_single
            assign w_word = INSTR_W'(bus.load_data);
        end else begin : g_multi
            logic [c_sh_w-1:0] r_shift;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_shift <= '0;
                end else if (w_accept) begin
                    r_shift <= c_sh_w'({r_shift, bus.load_data});
                end
            end
            assign w_word = INSTR_W'({r_shift, bus.load_data});
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= w_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_fetch_err   <= 1'b0;
        end else begin
            r_instr_valid <= 1'b0;
            r_fetch_err   <= 1'b0;
            if ((r_state == S_IDLE) && bus.fetch_en) begin
                r_instr_valid <= 1'b1;
                if ({1'b0, bus.fetch_addr} < r_word_count) begin
                    r_instr <= r_mem[bus.fetch_addr];
                end else begin
                    r_instr     <= '0;
                    r_fetch_err <= 1'b1;
                end
            end
        end
    end

    assign bus.load_ready  = (r_state == S_LOAD);
    assign bus.busy        = (r_state == S_LOAD);
    assign bus.load_done   = r_load_done;
    assign bus.word_count  = r_word_count;
    assign bus.instr       = r_instr;
    assign bus.instr_valid = r_instr_valid;
    assign bus.fetch_err   = r_fetch_err;
endmodule
`default_nettype wire

// File: tb/tb_program_store.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_store
// Purpose  : Randomized self-checking bench for program_store against a word-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_program_store;
    localparam int INSTR_W = 20;
    localparam int ADDR_W  = 4;
    localparam int DEPTH   = 16;

    logic clk = 1'b0;
    logic rst;

    program_store_if #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W)) bus ();

    program_store #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int                 n_vec = 0;
    int                 n_err = 0;
    logic [INSTR_W-1:0] model_mem [DEPTH];
    int                 model_wc;
    logic [INSTR_W-1:0] model_instr;
    logic [INSTR_W-1:0] ld_words [DEPTH];
    bit                 ld_junk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [INSTR_W-1:0] ref_fetch(input int a);
        return (a < model_wc) ? model_mem[a] : '0;
    endfunction

    // Byte idx 0 is the most significant; the spare top nibble may carry junk.
    function automatic logic [7:0] byte_of(input logic [INSTR_W-1:0] w, input int idx, input bit junk);
        logic [23:0] w24;
        logic [3:0]  top;
        top = junk ? 4'($urandom) : 4'h0;
        w24 = {top, w};
        return w24[8*(2-idx) +: 8];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        if ($urandom_range(3) == 0) tick();
        bus.load_valid = 1'b1;
        bus.load_data  = b;
        tick();
        bus.load_valid = 1'b0;
    endtask

    task automatic fetch_cycle(input int a);
        logic [INSTR_W-1:0] exp;
        exp = ref_fetch(a);
        bus.fetch_en   = 1'b1;
        bus.fetch_addr = ADDR_W'(a);
        tick();
        check("fetch_valid", 32'(bus.instr_valid), 32'(1));
        check("fetch_instr", 32'(bus.instr), 32'(exp));
        check("fetch_err", 32'(bus.fetch_err), 32'(a >= model_wc));
        model_instr = exp;
    endtask

    task automatic idle_check();
        bus.fetch_en = 1'b0;
        tick();
        check("idle_valid", 32'(bus.instr_valid), 32'(0));
        check("idle_err", 32'(bus.fetch_err), 32'(0));
        check("idle_instr_hold", 32'(bus.instr), 32'(model_instr));
    endtask

    task automatic fetch_batch(input int k);
        for (int j = 0; j < k; j++) begin
            if (model_wc > 0 && $urandom_range(3) != 0)
                fetch_cycle($urandom_range(model_wc - 1));
            else
                fetch_cycle($urandom_range(DEPTH - 1));
        end
        idle_check();
    endtask

    // Loads ld_words[0..n-1]; optional junk bytes then a restart before the
    // real words, and optional trailing partial-word bytes before load_end.
    task automatic do_load(input int n, input int partial, input int restart_bytes);
        int                 a;
        logic [INSTR_W-1:0] exp;
        a   = $urandom_range(DEPTH - 1);
        exp = ref_fetch(a);
        bus.load_start = 1'b1;
        bus.fetch_en   = 1'b1;
        bus.fetch_addr = ADDR_W'(a);
        tick();
        bus.load_start = 1'b0;
        bus.fetch_en   = 1'b0;
        check("start_fetch_valid", 32'(bus.instr_valid), 32'(1));
        check("start_fetch_instr", 32'(bus.instr), 32'(exp));
        check("start_fetch_err", 32'(bus.fetch_err), 32'(a >= model_wc));
        check("start_busy", 32'(bus.busy), 32'(1));
        check("start_ready", 32'(bus.load_ready), 32'(1));
        check("start_wc", 32'(bus.word_count), 32'(0));
        model_instr = exp;
        model_wc    = 0;

        if (restart_bytes > 0) begin
            for (int k = 0; k < restart_bytes; k++) send_byte(8'($urandom));
            bus.load_start = 1'b1;
            bus.load_end   = 1'b1;
            tick();
            bus.load_start = 1'b0;
            bus.load_end   = 1'b0;
            check("restart_no_done", 32'(bus.load_done), 32'(0));
            check("restart_busy", 32'(bus.busy), 32'(1));
            check("restart_wc", 32'(bus.word_count), 32'(0));
        end

        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 3; b++) begin
                bit mid_fetch;
                mid_fetch = (i == 0 && b == 0);
                if ($urandom_range(3) == 0) tick();
                bus.load_valid = 1'b1;
                bus.load_data  = byte_of(ld_words[i], b, ld_junk);
                if (mid_fetch) begin
                    bus.fetch_en   = 1'b1;
                    bus.fetch_addr = ADDR_W'($urandom);
                end
                tick();
                bus.load_valid = 1'b0;
                bus.fetch_en   = 1'b0;
                if (mid_fetch) begin
                    check("busy_fetch_valid", 32'(bus.instr_valid), 32'(0));
                    check("busy_fetch_hold", 32'(bus.instr), 32'(model_instr));
                end
            end
            model_mem[i] = ld_words[i];
            model_wc     = i + 1;
            check("load_wc", 32'(bus.word_count), 32'(model_wc));
            if (i == DEPTH - 1) begin
                check("full_done", 32'(bus.load_done), 32'(1));
                check("full_busy", 32'(bus.busy), 32'(0));
                check("full_ready", 32'(bus.load_ready), 32'(0));
            end
        end

        if (n < DEPTH) begin
            for (int k = 0; k < partial; k++) send_byte(8'($urandom));
            bus.load_end = 1'b1;
            tick();
            bus.load_end = 1'b0;
            check("end_done", 32'(bus.load_done), 32'(1));
            check("end_busy", 32'(bus.busy), 32'(0));
            check("end_wc", 32'(bus.word_count), 32'(model_wc));
        end
        tick();
        check("done_pulse_once", 32'(bus.load_done), 32'(0));
    endtask

    initial begin
        rst            = 1'b1;
        bus.load_start = 1'b0;
        bus.load_end   = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = 8'h00;
        bus.fetch_en   = 1'b0;
        bus.fetch_addr = '0;
        model_wc       = 0;
        model_instr    = '0;
        ld_junk        = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

        tick();
        tick();
        check("rst_instr", 32'(bus.instr), 32'(0));
        check("rst_valid", 32'(bus.instr_valid), 32'(0));
        check("rst_err", 32'(bus.fetch_err), 32'(0));
        check("rst_done", 32'(bus.load_done), 32'(0));
        check("rst_ready", 32'(bus.load_ready), 32'(0));
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_wc", 32'(bus.word_count), 32'(0));
        rst = 1'b0;
        tick();

        fetch_cycle(0);
        idle_check();

        // Directed three-word program from the bring-up example.
        ld_words[0] = 20'h8000A;
        ld_words[1] = 20'h8010C;
        ld_words[2] = 20'h00000;
        do_load(3, 0, 0);
        fetch_cycle(0);
        fetch_cycle(1);
        fetch_cycle(2);
        fetch_cycle(5);
        idle_check();

        // Partial word is dropped, next load starts cleanly on a word boundary.
        ld_junk = 1'b1;
        for (int i = 0; i < DEPTH; i++) ld_words[i] = INSTR_W'($urandom);
        do_load(2, 2, 0);
        fetch_batch(4);
        for (int i = 0; i < DEPTH; i++) ld_words[i] = INSTR_W'($urandom);
        do_load(3, 0, 0);
        fetch_cycle(0);
        fetch_cycle(2);
        fetch_cycle(3);
        idle_check();

        // Full store terminates on its own.
        for (int i = 0; i < DEPTH; i++) ld_words[i] = INSTR_W'($urandom);
        do_load(DEPTH, 0, 0);
        fetch_cycle(DEPTH - 1);
        fetch_batch(6);

        // Restart with load_start + load_end after some stray bytes.
        for (int i = 0; i < DEPTH; i++) ld_words[i] = INSTR_W'($urandom);
        do_load(2, 1, 4);
        fetch_batch(4);

        // Reset in the middle of a load.
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        for (int k = 0; k < 4; k++) send_byte(8'($urandom));
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'(0));
        check("midrst_ready", 32'(bus.load_ready), 32'(0));
        check("midrst_wc", 32'(bus.word_count), 32'(0));
        check("midrst_done", 32'(bus.load_done), 32'(0));
        check("midrst_instr", 32'(bus.instr), 32'(0));
        check("midrst_valid", 32'(bus.instr_valid), 32'(0));
        tick();
        rst = 1'b0;
        model_wc    = 0;
        model_instr = '0;
        tick();
        check("postrst_done", 32'(bus.load_done), 32'(0));
        fetch_cycle(0);
        idle_check();

        // Randomized programs.
        for (int it = 0; it < 10; it++) begin
            int n;
            int partial;
            int restart;
            n       = $urandom_range(DEPTH);
            partial = $urandom_range(2);
            restart = ($urandom_range(3) == 0) ? $urandom_range(1, 5) : 0;
            for (int i = 0; i < DEPTH; i++) ld_words[i] = INSTR_W'($urandom);
            do_load(n, partial, restart);
            fetch_batch(8);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
